wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
Shares the single register-file write port between two sources. The first is the in-order pipeline writeback stage, which has priority. The second is a late-result source (multicycle unit or memory response) that uses a valid/ready handshake. Late results are buffered in a small FIFO and written into idle write-port slots. The block stalls the pipeline to force a drain when the FIFO is full or its head has waited too long. It also kills buffered entries that a newer pipeline write has made stale (WAW).

Parameters:
DATA_W, 32, register data width (matches `DATA_W)
REG_ADDR_W, 5, register address width (matches `REG_ADDR_W)
DEPTH, 2, late-result FIFO entries (power of two, >=2)
MAX_WAIT, 4, cycles a non-empty FIFO head may wait before a forced drain (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_wr  in  1  pipeline writeback request (already gated by flush/stall upstream)
pipe_addr  in  REG_ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline result
pipe_stall  out  1  forced-drain stall to pipeline; pipe_wr is ignored this cycle and must be re-presented
lt_valid  in  1  late result valid
lt_ready  out  1  late result accepted when lt_valid && lt_ready
lt_addr  in  REG_ADDR_W  late destination register
lt_data  in  DATA_W  late result
regfile_wr  out  1  register-file write enable
regfile_addr_wr  out  REG_ADDR_W  write address
regfile_data_wr  out  DATA_W  write data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- State: FIFO of DEPTH entries {live bit, addr, data}; read pointer, write pointer, count; wait_cnt, which saturates at MAX_WAIT.
- Reset state: count=0, pointers=0, wait_cnt=0, all live bits=0. Consequences: regfile_wr=0, pipe_stall=0, lt_ready=1. Reset mid-operation discards all buffered entries.
- lt_ready = (count < DEPTH). It depends only on registered state.
- drain = (count != 0) && (wait_cnt == MAX_WAIT || count == DEPTH). It depends only on registered state, and pipe_stall = drain.
- Write-port selection is combinational, in priority order:
  1. drain: pop the head. regfile_wr = head.live, with head addr/data. pipe_wr is ignored.
  2. pipe_wr: write pipe_addr/pipe_data. No pop.
  3. count != 0: pop the head. regfile_wr = head.live.
  4. lt_valid && count == 0 (bypass): write lt_addr/lt_data directly. The handshake completes and nothing is pushed.
  5. Otherwise regfile_wr = 0. Address/data outputs are don't-care but must be driven.
- Push: occurs when lt_valid && lt_ready and the bypass (case 4) was not taken. The entry is written at the write pointer with live=1.
  - Push and pop may happen in the same cycle; count is then unchanged.
  - In a full-FIFO drain cycle, lt_ready is 0, so there is no push.
- WAW kill: when case 2 is taken, every entry with addr == pipe_addr gets live cleared at the clock edge.
  - An entry pushed in the same cycle with the same addr is NOT killed, because the late result is younger.
  - A killed entry still consumes one pop slot, with regfile_wr=0.
- wait_cnt:
  - Cleared on any pop, or when count becomes 0.
  - Incremented (saturating) each cycle count != 0 and no pop occurs.
- Forced drain lasts exactly one cycle per pop. Back-to-back drains can occur while the FIFO stays full.
- Pointers wrap modulo DEPTH. Overflow is impossible because pushes are gated by lt_ready. Underflow is impossible because pops are gated by count != 0.
- Address 0 gets no special handling; the register file owns that rule.

Test Plan:
- Reset with rst_n=0 mid-stream (FIFO count=2) -> regfile_wr=0, pipe_stall=0 and lt_ready=1 asynchronously; count=0 after release.
- Bypass: pipe_wr=0, FIFO empty, lt_valid=1, lt_addr=7, lt_data=0xA5 -> same-cycle regfile write r7=0xA5; count stays 0.
- Buffer and idle drain: cycle0 pipe_wr=1 (r3=0x11) with lt_valid=1 (r9=0x22) -> r3 written and entry pushed; cycle1 pipe_wr=0 -> r9=0x22 written, count=0.
- Starvation: push one entry, then hold pipe_wr=1 for 6 cycles -> wait_cnt reaches 4, so on the 5th cycle after the push pipe_stall=1 and the FIFO entry is written; pipe writes resume the next cycle.
- Full: DEPTH=2 filled while pipe_wr=1 continuously -> lt_ready=0 and pipe_stall=1 on the next cycle; one entry is popped per stall cycle.
- WAW kill: FIFO holds r5=0x55, then pipe writes r5=0x99 -> at pop, regfile_wr=0 and r5 keeps 0x99; a same-cycle push of r5 survives and is written later.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, late
// results are bypassed or buffered and drained into idle or forced slots.
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wr,
    input  logic [REG_ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_data,
    output logic                  pipe_stall,
    input  logic                  lt_valid,
    output logic                  lt_ready,
    input  logic [REG_ADDR_W-1:0] lt_addr,
    input  logic [DATA_W-1:0]     lt_data,
    output logic                  regfile_wr,
    output logic [REG_ADDR_W-1:0] regfile_addr_wr,
    output logic [DATA_W-1:0]     regfile_data_wr
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [DEPTH-1:0]      live_q;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [WAIT_W-1:0]     wait_cnt;

    logic empty;
    logic full;
    logic drain;
    logic pop;
    logic push;
    logic bypass;
    logic kill;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign lt_ready   = !full;
    assign drain      = !empty && (full || wait_cnt == WAIT_W'(MAX_WAIT));
    assign pipe_stall = drain;

    always_comb begin
        pop             = 1'b0;
        bypass          = 1'b0;
        kill            = 1'b0;
        regfile_wr      = 1'b0;
        regfile_addr_wr = '0;
        regfile_data_wr = '0;
        priority case (1'b1)
            drain: begin
                pop             = 1'b1;
                regfile_wr      = live_q[rd_ptr];
                regfile_addr_wr = addr_q[rd_ptr];
                regfile_data_wr = data_q[rd_ptr];
            end
            pipe_wr: begin
                kill            = 1'b1;
                regfile_wr      = 1'b1;
                regfile_addr_wr = pipe_addr;
                regfile_data_wr = pipe_data;
            end
            !empty: begin
                pop             = 1'b1;
                regfile_wr      = live_q[rd_ptr];
                regfile_addr_wr = addr_q[rd_ptr];
                regfile_data_wr = data_q[rd_ptr];
            end
            lt_valid: begin
                bypass          = 1'b1;
                regfile_wr      = 1'b1;
                regfile_addr_wr = lt_addr;
                regfile_data_wr = lt_data;
            end
            default: ;
        endcase
    end

    assign push      = lt_valid && lt_ready && !bypass;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Older buffered writes to the same register are now stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && addr_q[i] == pipe_addr) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (push) begin
                live_q[wr_ptr] <= 1'b1;
                addr_q[wr_ptr] <= lt_addr;
                data_q[wr_ptr] <= lt_data;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            if (pop || count_nxt == '0) begin
                wait_cnt <= '0;
            end else if (!empty && wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 2;
    localparam int MAX_WAIT   = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  pipe_wr;
    logic [REG_ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0]     pipe_data;
    logic                  pipe_stall;
    logic                  lt_valid;
    logic                  lt_ready;
    logic [REG_ADDR_W-1:0] lt_addr;
    logic [DATA_W-1:0]     lt_data;
    logic                  regfile_wr;
    logic [REG_ADDR_W-1:0] regfile_addr_wr;
    logic [DATA_W-1:0]     regfile_data_wr;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .DEPTH     (DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_wr        (pipe_wr),
        .pipe_addr      (pipe_addr),
        .pipe_data      (pipe_data),
        .pipe_stall     (pipe_stall),
        .lt_valid       (lt_valid),
        .lt_ready       (lt_ready),
        .lt_addr        (lt_addr),
        .lt_data        (lt_data),
        .regfile_wr     (regfile_wr),
        .regfile_addr_wr(regfile_addr_wr),
        .regfile_data_wr(regfile_data_wr)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of pending late results.
    typedef struct {
        bit                    live;
        logic [REG_ADDR_W-1:0] a;
        logic [DATA_W-1:0]     d;
    } ent_t;

    ent_t q[$];
    int   w;

    logic                  e_wr;
    logic                  e_stall;
    logic                  e_ready;
    logic [REG_ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0]     e_data;
    bit                    e_pop;
    bit                    e_bypass;

    task automatic drive(input logic pw, input logic [REG_ADDR_W-1:0] pa,
                         input logic [DATA_W-1:0] pd, input logic lv,
                         input logic [REG_ADDR_W-1:0] la,
                         input logic [DATA_W-1:0] ld);
        pipe_wr   = pw;
        pipe_addr = pa;
        pipe_data = pd;
        lt_valid  = lv;
        lt_addr   = la;
        lt_data   = ld;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        w = 0;
        tick();
    endtask

    task automatic model_eval();
        e_ready  = (q.size() < DEPTH);
        e_stall  = (q.size() != 0) && (w == MAX_WAIT || q.size() == DEPTH);
        e_pop    = 1'b0;
        e_bypass = 1'b0;
        e_wr     = 1'b0;
        e_addr   = '0;
        e_data   = '0;
        if (e_stall || (!pipe_wr && q.size() != 0)) begin
            e_pop  = 1'b1;
            e_wr   = q[0].live;
            e_addr = q[0].a;
            e_data = q[0].d;
        end else if (pipe_wr) begin
            e_wr   = 1'b1;
            e_addr = pipe_addr;
            e_data = pipe_data;
        end else if (lt_valid) begin
            e_bypass = 1'b1;
            e_wr     = 1'b1;
            e_addr   = lt_addr;
            e_data   = lt_data;
        end
    endtask

    task automatic model_commit();
        int n0;
        bit psh;
        ent_t e;
        n0  = q.size();
        psh = lt_valid && e_ready && !e_bypass;
        if (pipe_wr && !e_stall) begin
            foreach (q[i]) if (q[i].a == pipe_addr) q[i].live = 1'b0;
        end
        if (e_pop) void'(q.pop_front());
        if (psh) begin
            e.live = 1'b1;
            e.a    = lt_addr;
            e.d    = lt_data;
            q.push_back(e);
        end
        if (e_pop || q.size() == 0) w = 0;
        else if (n0 != 0 && w < MAX_WAIT) w++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (regfile_wr !== 1'b0 || pipe_stall !== 1'b0 || lt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: wr=%b stall=%b ready=%b, want 0/0/1",
                     regfile_wr, pipe_stall, lt_ready);
        end
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h10);
        tick();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'h11);
        tick();
        idle();
        settle();
        checks++;
        if (pipe_stall !== 1'b1 || lt_ready !== 1'b0 || regfile_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: stall=%b ready=%b wr=%b, want 1/0/1",
                     pipe_stall, lt_ready, regfile_wr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (regfile_wr !== 1'b0 || pipe_stall !== 1'b0 || lt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: wr=%b stall=%b ready=%b, want 0/0/1",
                     regfile_wr, pipe_stall, lt_ready);
        end
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd2, 32'h2);
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd2 || regfile_data_wr !== 32'h2) begin
            errors++;
            $display("FAIL reset_count0: wr=%b addr=%0d data=%h, want 1/2/2",
                     regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hA5);
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd7 ||
            regfile_data_wr !== 32'hA5 || lt_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass: wr=%b addr=%0d data=%h ready=%b, want 1/7/a5/1",
                     regfile_wr, regfile_addr_wr, regfile_data_wr, lt_ready);
        end
        tick();
        idle();
        settle();
        checks++;
        if (regfile_wr !== 1'b0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL bypass_empty: wr=%b stall=%b, want 0/0", regfile_wr, pipe_stall);
        end
        tick();
    endtask

    task automatic test_buffer();
        do_reset();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd9, 32'h22);
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd3 || regfile_data_wr !== 32'h11) begin
            errors++;
            $display("FAIL buffer_pipe: wr=%b addr=%0d data=%h, want 1/3/11",
                     regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        idle();
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd9 ||
            regfile_data_wr !== 32'h22 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL buffer_drain: wr=%b addr=%0d data=%h stall=%b, want 1/9/22/0",
                     regfile_wr, regfile_addr_wr, regfile_data_wr, pipe_stall);
        end
        tick();
        settle();
        checks++;
        if (regfile_wr !== 1'b0) begin
            errors++;
            $display("FAIL buffer_empty: wr=%b, want 0", regfile_wr);
        end
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h77);
        tick();
        for (int c = 1; c <= 6; c++) begin
            drive(1'b1, 5'd2, 32'(c), 1'b0, '0, '0);
            settle();
            checks++;
            if (c == 5) begin
                if (pipe_stall !== 1'b1 || regfile_wr !== 1'b1 ||
                    regfile_addr_wr !== 5'd20 || regfile_data_wr !== 32'h77) begin
                    errors++;
                    $display("FAIL starve_drain c%0d: stall=%b wr=%b addr=%0d data=%h, want 1/1/20/77",
                             c, pipe_stall, regfile_wr, regfile_addr_wr, regfile_data_wr);
                end
            end else if (pipe_stall !== 1'b0 || regfile_wr !== 1'b1 ||
                         regfile_addr_wr !== 5'd2 || regfile_data_wr !== 32'(c)) begin
                errors++;
                $display("FAIL starve_pipe c%0d: stall=%b wr=%b addr=%0d data=%h, want 0/1/2/%0h",
                         c, pipe_stall, regfile_wr, regfile_addr_wr, regfile_data_wr, c);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC1);
        tick();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 32'hC2);
        tick();
        drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd14, 32'hC3);
        settle();
        checks++;
        if (lt_ready !== 1'b0 || pipe_stall !== 1'b1 || regfile_wr !== 1'b1 ||
            regfile_addr_wr !== 5'd12 || regfile_data_wr !== 32'hC1) begin
            errors++;
            $display("FAIL full_drain1: ready=%b stall=%b wr=%b addr=%0d data=%h, want 0/1/1/12/c1",
                     lt_ready, pipe_stall, regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        settle();
        checks++;
        if (pipe_stall !== 1'b0 || lt_ready !== 1'b1 ||
            regfile_addr_wr !== 5'd4 || regfile_data_wr !== 32'h4) begin
            errors++;
            $display("FAIL full_resume: stall=%b ready=%b addr=%0d data=%h, want 0/1/4/4",
                     pipe_stall, lt_ready, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        drive(1'b1, 5'd4, 32'h5, 1'b0, '0, '0);
        settle();
        checks++;
        if (pipe_stall !== 1'b1 || regfile_wr !== 1'b1 ||
            regfile_addr_wr !== 5'd13 || regfile_data_wr !== 32'hC2) begin
            errors++;
            $display("FAIL full_drain2: stall=%b wr=%b addr=%0d data=%h, want 1/1/13/c2",
                     pipe_stall, regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        idle();
        settle();
        checks++;
        if (pipe_stall !== 1'b0 || regfile_wr !== 1'b1 ||
            regfile_addr_wr !== 5'd14 || regfile_data_wr !== 32'hC3) begin
            errors++;
            $display("FAIL full_last: stall=%b wr=%b addr=%0d data=%h, want 0/1/14/c3",
                     pipe_stall, regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
        tick();
        drive(1'b1, 5'd5, 32'h99, 1'b0, '0, '0);
        tick();
        idle();
        settle();
        checks++;
        if (regfile_wr !== 1'b0 || pipe_stall !== 1'b0) begin
            errors++;
            $display("FAIL waw_kill: wr=%b stall=%b, want 0/0", regfile_wr, pipe_stall);
        end
        tick();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55);
        tick();
        drive(1'b1, 5'd5, 32'h99, 1'b1, 5'd5, 32'h66);
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd5 || regfile_data_wr !== 32'h99) begin
            errors++;
            $display("FAIL waw_pipe: wr=%b addr=%0d data=%h, want 1/5/99",
                     regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
        idle();
        settle();
        checks++;
        if (regfile_wr !== 1'b0 || pipe_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_killed_pop: wr=%b stall=%b, want 0/1", regfile_wr, pipe_stall);
        end
        tick();
        settle();
        checks++;
        if (regfile_wr !== 1'b1 || regfile_addr_wr !== 5'd5 || regfile_data_wr !== 32'h66) begin
            errors++;
            $display("FAIL waw_survivor: wr=%b addr=%0d data=%h, want 1/5/66",
                     regfile_wr, regfile_addr_wr, regfile_data_wr);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  REG_ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  REG_ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom));
            settle();
            model_eval();
            checks++;
            if ({pipe_stall, lt_ready, regfile_wr} !== {e_stall, e_ready, e_wr}) begin
                errors++;
                $display("FAIL rand_ctrl n%0d: stall/ready/wr=%b%b%b, want %b%b%b",
                         n, pipe_stall, lt_ready, regfile_wr, e_stall, e_ready, e_wr);
            end
            if (e_wr) begin
                checks++;
                if (regfile_addr_wr !== e_addr || regfile_data_wr !== e_data) begin
                    errors++;
                    $display("FAIL rand_write n%0d: addr=%0d data=%h, want %0d/%h",
                             n, regfile_addr_wr, regfile_data_wr, e_addr, e_data);
                end
            end
            tick();
            model_commit();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_buffer();
        test_starvation();
        test_full();
        test_waw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
